// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard
// Load-use hazard unit that sits beside the ID stage. It keeps a bitmap of
// destination registers whose load data has not returned yet. It stalls IF/ID
// and injects an ID/EX bubble while the decoded instruction depends on one of
// those registers. With FWD_EN=1 the load data can be bypassed in the same
// cycle it returns.
//
// Handshake: a load is tracked when ex_issue & ex_is_load is seen at a rising
// edge, and it is released when mem_rsp_valid is seen at a rising edge. There
// is no backpressure on either side. The ID instruction advances only when
// stall_if_id is low.
module load_use_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int MAX_PENDING    = 4,
    parameter bit FWD_EN         = 1'b1,
    parameter int CNT_WIDTH      = 32,
    localparam int PW            = $clog2(MAX_PENDING + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic                      id_rs1_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs2_used,
    input  logic                      id_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      ex_issue,
    input  logic                      ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      mem_rsp_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rsp_rd,
    output logic                      stall_if_id,
    output logic                      bubble_id_ex,
    output logic                      fwd_rs1,
    output logic                      fwd_rs2,
    output logic [PW-1:0]             pending_cnt,
    output logic                      full,
    output logic                      err,
    output logic [CNT_WIDTH-1:0]      stall_cycles
);

    // Bit 0 (x0) is never stored; it is tied to zero in the full-width view.
    logic [NUM_REGS-1:1] r_pending;
    logic [PW-1:0]       r_cnt;
    logic                r_err;
    logic [CNT_WIDTH-1:0] r_stall_cycles;

    logic [NUM_REGS-1:0] w_pending;
    logic                w_full;
    logic                w_hz_rs1_raw;
    logic                w_hz_rs2_raw;
    logic                w_byp_rs1;
    logic                w_byp_rs2;
    logic                w_byp_rd;
    logic                w_hz_rs1;
    logic                w_hz_rs2;
    logic                w_hz_waw;
    logic                w_hz_cap;
    logic                w_stall;
    logic                w_set;
    logic                w_clr;
    logic                w_set_dup;
    logic                w_set_drop;
    logic                w_set_eff;
    logic                w_rsp_bad;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_pending_nxt;

    assign w_pending = {r_pending, 1'b0};
    assign w_full    = (r_cnt == PW'(MAX_PENDING));

    // Hazard detection: source RAW, destination WAW and capacity checks for the ID instruction.
    always_comb begin
        w_hz_rs1_raw = id_valid & id_rs1_used & (id_rs1_addr != '0) & w_pending[id_rs1_addr];
        w_hz_rs2_raw = id_valid & id_rs2_used & (id_rs2_addr != '0) & w_pending[id_rs2_addr];
        w_byp_rs1    = FWD_EN & mem_rsp_valid & (mem_rsp_rd == id_rs1_addr);
        w_byp_rs2    = FWD_EN & mem_rsp_valid & (mem_rsp_rd == id_rs2_addr);
        w_byp_rd     = FWD_EN & mem_rsp_valid & (mem_rsp_rd == id_rd_addr);
        w_hz_rs1     = w_hz_rs1_raw & ~w_byp_rs1;
        w_hz_rs2     = w_hz_rs2_raw & ~w_byp_rs2;
        w_hz_waw     = id_valid & id_is_load & (id_rd_addr != '0) &
                       w_pending[id_rd_addr] & ~w_byp_rd;
        // A load to x0 is discarded, so it never has to wait for a free slot.
        w_hz_cap     = id_valid & id_is_load & (id_rd_addr != '0) & w_full & ~mem_rsp_valid;
        w_stall      = w_hz_rs1 | w_hz_rs2 | w_hz_waw | w_hz_cap;
    end

    // Update classification: which set/clear actually changes the bitmap and which is a violation.
    always_comb begin
        w_set      = ex_issue & ex_is_load & (ex_rd_addr != '0);
        w_clr      = mem_rsp_valid & (mem_rsp_rd != '0) & w_pending[mem_rsp_rd];
        w_rsp_bad  = mem_rsp_valid & ~w_clr;
        // A reissue to a register that is released in the same cycle is a legal replacement.
        w_set_dup  = w_set & w_pending[ex_rd_addr] & ~(w_clr & (mem_rsp_rd == ex_rd_addr));
        // Only a real release frees a slot, so the count can never pass MAX_PENDING.
        w_set_drop = w_set & w_full & ~w_clr;
        w_set_eff  = w_set & ~w_set_dup & ~w_set_drop;
        w_set_mask = {{(NUM_REGS-1){1'b0}}, w_set_eff} << ex_rd_addr;
        w_clr_mask = {{(NUM_REGS-1){1'b0}}, w_clr} << mem_rsp_rd;
        // A set wins over a clear when both target the same register.
        w_pending_nxt = (w_pending & ~w_clr_mask) | w_set_mask;
    end

    // State update: bitmap, outstanding count, sticky error and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending      <= '0;
            r_cnt          <= '0;
            r_err          <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_pending <= w_pending_nxt[NUM_REGS-1:1];
            r_cnt     <= r_cnt + PW'(w_set_eff) - PW'(w_clr);
            if (w_rsp_bad | w_set_dup | w_set_drop) begin
                r_err <= 1'b1;
            end
            if (w_stall && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign stall_if_id  = w_stall;
    assign bubble_id_ex = w_stall;
    assign fwd_rs1      = w_hz_rs1_raw & w_byp_rs1;
    assign fwd_rs2      = w_hz_rs2_raw & w_byp_rs2;
    assign pending_cnt  = r_cnt;
    assign full         = w_full;
    assign err          = r_err;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard. Two instances share every input:
// u_fwd (FWD_EN=1) and u_nofwd (FWD_EN=0). Inputs change 1 ns after each
// rising edge. Outputs are sampled a few ns later, well away from the edge.
module tb_load_use_scoreboard;
    localparam int AW = 5;
    localparam int PW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          id_valid, id_rs1_used, id_rs2_used, id_is_load;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic          ex_issue, ex_is_load;
    logic [AW-1:0] ex_rd_addr;
    logic          mem_rsp_valid;
    logic [AW-1:0] mem_rsp_rd;

    logic          stall_f, bubble_f, fwd_rs1_f, fwd_rs2_f, full_f, err_f;
    logic [PW-1:0] cnt_f;
    logic [31:0]   sc_f;
    logic          stall_n, bubble_n, fwd_rs1_n, fwd_rs2_n, full_n, err_n;
    logic [PW-1:0] cnt_n;
    logic [31:0]   sc_n;

    int n_tests = 0;
    int n_fail  = 0;

    load_use_scoreboard #(.FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
        .id_is_load(id_is_load), .id_rd_addr(id_rd_addr),
        .ex_issue(ex_issue), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rd(mem_rsp_rd),
        .stall_if_id(stall_f), .bubble_id_ex(bubble_f),
        .fwd_rs1(fwd_rs1_f), .fwd_rs2(fwd_rs2_f),
        .pending_cnt(cnt_f), .full(full_f), .err(err_f), .stall_cycles(sc_f)
    );

    load_use_scoreboard #(.FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
        .id_is_load(id_is_load), .id_rd_addr(id_rd_addr),
        .ex_issue(ex_issue), .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rd(mem_rsp_rd),
        .stall_if_id(stall_n), .bubble_id_ex(bubble_n),
        .fwd_rs1(fwd_rs1_n), .fwd_rs2(fwd_rs2_n),
        .pending_cnt(cnt_n), .full(full_n), .err(err_n), .stall_cycles(sc_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_is_load = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        ex_issue = 1'b0; ex_is_load = 1'b0; ex_rd_addr = '0;
        mem_rsp_valid = 1'b0; mem_rsp_rd = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [AW-1:0] rd);
        ex_issue = 1'b1; ex_is_load = 1'b1; ex_rd_addr = rd;
    endtask

    task automatic respond(input logic [AW-1:0] rd);
        mem_rsp_valid = 1'b1; mem_rsp_rd = rd;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #12;
        check("rst_cnt",   32'(cnt_f), 32'd0);
        check("rst_stall", 32'(stall_f), 32'd0);
        check("rst_err",   32'(err_f), 32'd0);
        check("rst_full",  32'(full_f), 32'd0);
        check("rst_sc",    sc_f, 32'd0);
        cycle();
        rst = 1'b0;

        // Test 1/2: lw x7, then addi x8,x7,1 waits in ID; response arrives two cycles later.
        issue_load(5'd7);
        #2 check("t1_no_stall_at_issue", 32'(stall_f), 32'd0);
        cycle();
        idle();
        id_valid = 1'b1; id_rs1_addr = 5'd7; id_rs1_used = 1'b1; id_rd_addr = 5'd8;
        #2 check("t1_stall_c1", 32'(stall_f), 32'd1);
        check("t1_bubble_c1", 32'(bubble_f), 32'd1);
        check("t1_cnt", 32'(cnt_f), 32'd1);
        cycle();
        #2 check("t1_stall_c2", 32'(stall_f), 32'd1);
        cycle();
        respond(5'd7);
        #2 check("t1_fwd_stall_rsp", 32'(stall_f), 32'd0);
        check("t1_fwd_rs1", 32'(fwd_rs1_f), 32'd1);
        check("t1_fwd_rs2", 32'(fwd_rs2_f), 32'd0);
        check("t2_nofwd_stall_rsp", 32'(stall_n), 32'd1);
        check("t2_nofwd_fwd_rs1", 32'(fwd_rs1_n), 32'd0);
        cycle();
        mem_rsp_valid = 1'b0;
        #2 check("t2_nofwd_stall_after", 32'(stall_n), 32'd0);
        check("t1_cnt_after", 32'(cnt_f), 32'd0);
        check("t2_cnt_after", 32'(cnt_n), 32'd0);
        check("t1_stall_cycles", sc_f, 32'd2);
        check("t2_stall_cycles", sc_n, 32'd3);
        check("t1_err", 32'(err_f), 32'd0);
        cycle();

        // Test 3: fill all four slots, then a load in ID waits on capacity.
        idle();
        for (int i = 1; i <= 4; i++) begin
            issue_load(AW'(i));
            cycle();
        end
        idle();
        #2 check("t3_cnt_full", 32'(cnt_f), 32'd4);
        check("t3_full", 32'(full_f), 32'd1);
        id_valid = 1'b1; id_is_load = 1'b1; id_rd_addr = 5'd9;
        id_rs1_addr = 5'd10; id_rs1_used = 1'b1;
        #1 check("t3_cap_stall", 32'(stall_f), 32'd1);
        check("t3_cap_stall_nofwd", 32'(stall_n), 32'd1);
        cycle();
        respond(5'd2);
        issue_load(5'd9);
        #2 check("t3_cap_rsp_no_stall", 32'(stall_f), 32'd0);
        check("t3_cap_rsp_no_stall_nofwd", 32'(stall_n), 32'd0);
        cycle();
        idle();
        #2 check("t3_cnt_kept", 32'(cnt_f), 32'd4);
        check("t3_full_kept", 32'(full_f), 32'd1);
        check("t3_err", 32'(err_f), 32'd0);
        check("t3_stall_cycles", sc_f, 32'd3);

        // Test 4: release x1 and x3, track x5, then reissue x5 while it returns.
        respond(5'd1);
        cycle();
        respond(5'd3);
        cycle();
        idle();
        issue_load(5'd5);
        cycle();
        idle();
        issue_load(5'd5);
        respond(5'd5);
        cycle();
        idle();
        #2 check("t4_cnt_same_cycle", 32'(cnt_f), 32'd3);
        check("t4_err", 32'(err_f), 32'd0);
        id_valid = 1'b1;
        id_rs1_addr = 5'd9; id_rs1_used = 1'b1;
        id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
        respond(5'd5);
        #1 check("t4_rs1_still_stalls", 32'(stall_f), 32'd1);
        check("t4_fwd_rs1_off", 32'(fwd_rs1_f), 32'd0);
        check("t4_fwd_rs2_on", 32'(fwd_rs2_f), 32'd1);
        id_rs1_used = 1'b0;
        #1 check("t4_rs2_bypass", 32'(stall_f), 32'd0);
        check("t4_rs2_nofwd_stall", 32'(stall_n), 32'd1);
        id_rs2_used = 1'b0; id_is_load = 1'b1; id_rd_addr = 5'd4;
        #1 check("t4_waw_stall", 32'(stall_f), 32'd1);
        mem_rsp_rd = 5'd4;
        #1 check("t4_waw_bypass", 32'(stall_f), 32'd0);
        check("t4_waw_nofwd", 32'(stall_n), 32'd1);
        idle();
        cycle();

        // Test 5: response to x6, which is not pending.
        respond(5'd6);
        cycle();
        idle();
        #2 check("t5_err_x6", 32'(err_f), 32'd1);
        check("t5_cnt_unchanged", 32'(cnt_f), 32'd3);
        id_valid = 1'b1; id_rs1_addr = 5'd4; id_rs1_used = 1'b1;
        #1 check("t5_bitmap_kept", 32'(stall_f), 32'd1);
        cycle();
        #2 check("t5_err_sticky", 32'(err_f), 32'd1);

        // Test 6: asynchronous reset between clock edges with loads pending.
        rst = 1'b1;
        #1 check("t6_cnt_async", 32'(cnt_f), 32'd0);
        check("t6_stall_async", 32'(stall_f), 32'd0);
        check("t6_err_async", 32'(err_f), 32'd0);
        check("t6_sc_async", sc_f, 32'd0);
        cycle();
        rst = 1'b0;
        idle();

        // Response to x0 sets err; the bitmap stays empty.
        respond(5'd0);
        cycle();
        idle();
        #2 check("t5_err_x0", 32'(err_f), 32'd1);
        check("t5_cnt_x0", 32'(cnt_f), 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
